// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encoding and the operand bundle handed to execute.
package cpu_pkg;

    localparam int OP_W   = 4;
    localparam int DATA_W = 8;
    localparam int REG_AW = 4;

    typedef logic [OP_W-1:0] opcode_t;

    localparam opcode_t OP_ADD = 4'h0;
    localparam opcode_t OP_SUB = 4'h1;
    localparam opcode_t OP_AND = 4'h2;
    localparam opcode_t OP_OR  = 4'h3;
    localparam opcode_t OP_XOR = 4'h4;
    localparam opcode_t OP_SLL = 4'h5;
    localparam opcode_t OP_SRL = 4'h6;
    localparam opcode_t OP_LD  = 4'h8;
    localparam opcode_t OP_ST  = 4'h9;

    // Default-width view of the bundle; operand_stage builds the same layout from its parameters.
    typedef struct packed {
        opcode_t             op;
        logic [DATA_W-1:0]   a;
        logic [DATA_W-1:0]   b;
        logic [REG_AW-1:0]   rd_addr;
        logic                rd_we;
    } operand_bundle_t;

endpackage

// File: rtl/operand_stage_scoreboard.sv
// One pending bit per architectural register; a set from a new issue wins over a same-cycle clear.
module operand_stage_scoreboard #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     set_en_i,
    input  logic [ADDR_WIDTH-1:0]    set_addr_i,
    input  logic                     clr_en_i,
    input  logic [ADDR_WIDTH-1:0]    clr_addr_i,
    input  logic                     flush_clr_en_i,
    input  logic [ADDR_WIDTH-1:0]    flush_clr_addr_i,
    output logic [2**ADDR_WIDTH-1:0] pending_o
);

    localparam int NREG = 2**ADDR_WIDTH;

    logic [NREG-1:0] pending_d, pending_q;

    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < NREG; i++) begin
            if (set_en_i && set_addr_i == ADDR_WIDTH'(i)) begin
                pending_d[i] = 1'b1;
            end else if ((clr_en_i && clr_addr_i == ADDR_WIDTH'(i)) ||
                         (flush_clr_en_i && flush_clr_addr_i == ADDR_WIDTH'(i))) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/operand_stage.sv
// Register-read/issue stage: reads operands with write-back bypass, stalls on RAW/WAW
// hazards via a pending-register scoreboard, and holds a registered bundle for execute.
module operand_stage
    import cpu_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int WIDTH      = 8,
    parameter int OP_WIDTH   = 4,
    parameter bit ZERO_REG   = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    output logic                  id_ready,
    input  logic [OP_WIDTH-1:0]   id_op,
    input  logic [ADDR_WIDTH-1:0] id_rs1_addr,
    input  logic [ADDR_WIDTH-1:0] id_rs2_addr,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [ADDR_WIDTH-1:0] id_rd_addr,
    input  logic                  id_rd_we,
    input  logic [WIDTH-1:0]      id_imm,
    input  logic                  id_use_imm,
    output logic [ADDR_WIDTH-1:0] rs1_addr,
    output logic [ADDR_WIDTH-1:0] rs2_addr,
    input  logic [WIDTH-1:0]      rs1_data,
    input  logic [WIDTH-1:0]      rs2_data,
    input  logic                  wb_we,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [WIDTH-1:0]      wb_data,
    input  logic                  flush,
    output logic                  ex_valid,
    input  logic                  ex_ready,
    output logic [OP_WIDTH-1:0]   ex_op,
    output logic [WIDTH-1:0]      ex_a,
    output logic [WIDTH-1:0]      ex_b,
    output logic [ADDR_WIDTH-1:0] ex_rd_addr,
    output logic                  ex_rd_we
);

    localparam int NREG = 2**ADDR_WIDTH;

    typedef struct packed {
        logic [OP_WIDTH-1:0]   op;
        logic [WIDTH-1:0]      a;
        logic [WIDTH-1:0]      b;
        logic [ADDR_WIDTH-1:0] rd_addr;
        logic                  rd_we;
    } bundle_t;

    function automatic logic is_zero(input logic [ADDR_WIDTH-1:0] r);
        return ZERO_REG && (r == '0);
    endfunction

    function automatic logic wb_hit(input logic [ADDR_WIDTH-1:0] r, input logic we,
                                    input logic [ADDR_WIDTH-1:0] wa);
        return we && (wa == r);
    endfunction

    logic [NREG-1:0] pending;
    logic            raw1, raw2, waw, accept;
    logic [WIDTH-1:0] opa, opb;
    bundle_t         bundle_d, bundle_q;
    logic            ex_valid_d, ex_valid_q;

    assign rs1_addr = id_rs1_addr;
    assign rs2_addr = id_rs2_addr;

    // A write-back landing this cycle resolves the hazard, so it never stalls.
    always_comb begin
        raw1 = id_rs1_used && !is_zero(id_rs1_addr) && pending[id_rs1_addr]
               && !wb_hit(id_rs1_addr, wb_we, wb_addr);
        raw2 = id_rs2_used && !is_zero(id_rs2_addr) && pending[id_rs2_addr]
               && !wb_hit(id_rs2_addr, wb_we, wb_addr);
        waw  = id_rd_we && !is_zero(id_rd_addr) && pending[id_rd_addr]
               && !wb_hit(id_rd_addr, wb_we, wb_addr);
    end

    assign id_ready = !rst && !flush && !raw1 && !raw2 && !waw && (!ex_valid_q || ex_ready);
    assign accept   = id_valid && id_ready;

    always_comb begin
        if (is_zero(id_rs1_addr))                      opa = '0;
        else if (wb_hit(id_rs1_addr, wb_we, wb_addr))  opa = wb_data;
        else                                           opa = rs1_data;

        if (id_use_imm)                                opb = id_imm;
        else if (is_zero(id_rs2_addr))                 opb = '0;
        else if (wb_hit(id_rs2_addr, wb_we, wb_addr))  opb = wb_data;
        else                                           opb = rs2_data;
    end

    always_comb begin
        bundle_d   = bundle_q;
        ex_valid_d = ex_valid_q;
        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d       = 1'b1;
            bundle_d.op      = id_op;
            bundle_d.a       = opa;
            bundle_d.b       = opb;
            bundle_d.rd_addr = id_rd_addr;
            bundle_d.rd_we   = id_rd_we;
        end else if (ex_ready) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid_q <= 1'b0;
            bundle_q   <= '0;
        end else begin
            ex_valid_q <= ex_valid_d;
            bundle_q   <= bundle_d;
        end
    end

    operand_stage_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_sb (
        .clk              (clk),
        .rst              (rst),
        .set_en_i         (accept && id_rd_we && !is_zero(id_rd_addr)),
        .set_addr_i       (id_rd_addr),
        .clr_en_i         (wb_we),
        .clr_addr_i       (wb_addr),
        .flush_clr_en_i   (flush && ex_valid_q && bundle_q.rd_we),
        .flush_clr_addr_i (bundle_q.rd_addr),
        .pending_o        (pending)
    );

    assign ex_valid   = ex_valid_q;
    assign ex_op      = bundle_q.op;
    assign ex_a       = bundle_q.a;
    assign ex_b       = bundle_q.b;
    assign ex_rd_addr = bundle_q.rd_addr;
    assign ex_rd_we   = bundle_q.rd_we;

endmodule

// File: tb/tb_operand_stage.sv
// Bench for operand_stage: scenario tasks with inline checks plus a queue-based
// scoreboard that matches every bundle consumed by execute.
module tb_operand_stage;
  import cpu_pkg::*;

  localparam int AW = 4;
  localparam int W  = 8;
  localparam int OW = 4;

  logic          clk, rst;
  logic          id_valid, id_ready;
  logic [OW-1:0] id_op;
  logic [AW-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic          id_rs1_used, id_rs2_used, id_rd_we, id_use_imm;
  logic [W-1:0]  id_imm;
  logic [AW-1:0] rs1_addr, rs2_addr;
  logic [W-1:0]  rs1_data, rs2_data;
  logic          wb_we;
  logic [AW-1:0] wb_addr;
  logic [W-1:0]  wb_data;
  logic          flush;
  logic          ex_valid, ex_ready;
  logic [OW-1:0] ex_op;
  logic [W-1:0]  ex_a, ex_b;
  logic [AW-1:0] ex_rd_addr;
  logic          ex_rd_we;

  typedef struct packed {
    logic [OW-1:0] op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [AW-1:0] rd;
    logic          we;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  operand_stage #(.ADDR_WIDTH(AW), .WIDTH(W), .OP_WIDTH(OW), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_ready(id_ready), .id_op(id_op),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd_addr(id_rd_addr), .id_rd_we(id_rd_we),
    .id_imm(id_imm), .id_use_imm(id_use_imm),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
    .ex_a(ex_a), .ex_b(ex_b), .ex_rd_addr(ex_rd_addr), .ex_rd_we(ex_rd_we)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model_src(input logic [AW-1:0] r, input logic [W-1:0] rf);
    if (r == '0) return '0;
    if (wb_we && wb_addr == r) return wb_data;
    return rf;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_id(input logic [OW-1:0] op, input logic [AW-1:0] rs1, input logic u1,
                          input logic [AW-1:0] rs2, input logic u2, input logic [AW-1:0] rd,
                          input logic we, input logic [W-1:0] imm, input logic ui,
                          input logic [W-1:0] d1, input logic [W-1:0] d2);
    id_valid = 1'b1; id_op = op;
    id_rs1_addr = rs1; id_rs1_used = u1; id_rs2_addr = rs2; id_rs2_used = u2;
    id_rd_addr = rd; id_rd_we = we; id_imm = imm; id_use_imm = ui;
    rs1_data = d1; rs2_data = d2;
  endtask

  task automatic idle();
    id_valid = 1'b0; id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_rd_we = 1'b0;
  endtask

  task automatic push_exp();
    exp_t e;
    e.op = id_op;
    e.a  = model_src(id_rs1_addr, rs1_data);
    e.b  = id_use_imm ? id_imm : model_src(id_rs2_addr, rs2_data);
    e.rd = id_rd_addr;
    e.we = id_rd_we;
    exp_q.push_back(e);
  endtask

  // ---------------- scoreboard monitor ----------------
  always begin
    @(negedge clk);
    #2;
    if (!rst && ex_valid && ex_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got bundle op=%h a=%h b=%h, want no bundle", ex_op, ex_a, ex_b);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (ex_op !== e.op || ex_a !== e.a || ex_b !== e.b || ex_rd_addr !== e.rd || ex_rd_we !== e.we) begin
          n_err++;
          $display("FAIL sb_bundle: got op=%h a=%h b=%h rd=%h we=%b want op=%h a=%h b=%h rd=%h we=%b",
                   ex_op, ex_a, ex_b, ex_rd_addr, ex_rd_we, e.op, e.a, e.b, e.rd, e.we);
        end
      end
    end
  end

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    #1;
    n_cmp++;
    if (ex_valid !== 1'b0 || ex_op !== '0 || ex_a !== '0 || ex_b !== '0 || ex_rd_addr !== '0 || ex_rd_we !== 1'b0) begin
      n_err++;
      $display("FAIL reset_outputs: got v=%b op=%h a=%h b=%h rd=%h we=%b want all 0",
               ex_valid, ex_op, ex_a, ex_b, ex_rd_addr, ex_rd_we);
    end
    n_cmp++;
    if (dut.u_sb.pending_o !== 16'h0) begin
      n_err++; $display("FAIL reset_pending: got %h want 0000", dut.u_sb.pending_o);
    end
    n_cmp++;
    if (id_ready !== 1'b0) begin
      n_err++; $display("FAIL reset_id_ready: got %b want 0", id_ready);
    end
    rst = 1'b0;
    ex_ready = 1'b1;
  endtask

  task automatic test_basic();
    @(negedge clk);
    drive_id(OP_ADD, 4'd2, 1'b1, 4'd0, 1'b0, 4'd4, 1'b1, 8'h05, 1'b1, 8'h11, 8'h00);
    #1;
    n_cmp++;
    if (id_ready !== 1'b1) begin n_err++; $display("FAIL basic_ready: got %b want 1", id_ready); end
    push_exp();
    @(negedge clk);
    idle();
    #1;
    n_cmp++;
    if (ex_valid !== 1'b1 || ex_a !== 8'h11 || ex_b !== 8'h05 || ex_rd_addr !== 4'd4) begin
      n_err++;
      $display("FAIL basic_bundle: got v=%b a=%h b=%h rd=%h want v=1 a=11 b=05 rd=4", ex_valid, ex_a, ex_b, ex_rd_addr);
    end
    n_cmp++;
    if (dut.u_sb.pending_o[4] !== 1'b1) begin n_err++; $display("FAIL basic_pending4: got %b want 1", dut.u_sb.pending_o[4]); end
  endtask

  task automatic test_raw_bypass();
    @(negedge clk);
    drive_id(OP_SUB, 4'd4, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 8'h03, 1'b1, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_cmp++;
      if (id_ready !== 1'b0) begin n_err++; $display("FAIL raw_stall cycle %0d: got %b want 0", i, id_ready); end
    end
    @(negedge clk);
    wb_we = 1'b1; wb_addr = 4'd4; wb_data = 8'hA5;
    #1;
    n_cmp++;
    if (id_ready !== 1'b1) begin n_err++; $display("FAIL raw_release: got %b want 1", id_ready); end
    push_exp();
    @(negedge clk);
    wb_we = 1'b0;
    idle();
    #1;
    n_cmp++;
    if (ex_a !== 8'hA5) begin n_err++; $display("FAIL raw_bypass_a: got %h want a5", ex_a); end
    n_cmp++;
    if (dut.u_sb.pending_o[4] !== 1'b0 || dut.u_sb.pending_o[5] !== 1'b1) begin
      n_err++; $display("FAIL raw_pending: got %h want 0020", dut.u_sb.pending_o);
    end
    @(negedge clk);
    wb_we = 1'b1; wb_addr = 4'd5; wb_data = W'($urandom_range(0, 255));
    @(negedge clk);
    wb_we = 1'b1; wb_addr = 4'd11; wb_data = 8'h00;
    @(negedge clk);
    wb_we = 1'b0;
    #1;
    n_cmp++;
    if (dut.u_sb.pending_o !== 16'h0) begin n_err++; $display("FAIL raw_cleanup: got %h want 0000", dut.u_sb.pending_o); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    drive_id(OP_AND, 4'd0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 8'h07, 1'b1, 8'hFF, 8'h00);
    #1;
    n_cmp++;
    if (id_ready !== 1'b1) begin n_err++; $display("FAIL zero_ready1: got %b want 1", id_ready); end
    push_exp();
    @(negedge clk);
    drive_id(OP_OR, 4'd0, 1'b1, 4'd0, 1'b1, 4'd1, 1'b0, 8'h00, 1'b0, 8'hFF, 8'hFF);
    #1;
    n_cmp++;
    if (ex_a !== 8'h00) begin n_err++; $display("FAIL zero_ex_a: got %h want 00", ex_a); end
    n_cmp++;
    if (dut.u_sb.pending_o[0] !== 1'b0) begin n_err++; $display("FAIL zero_pending0: got %b want 0", dut.u_sb.pending_o[0]); end
    n_cmp++;
    if (id_ready !== 1'b1) begin n_err++; $display("FAIL zero_reader_ready: got %b want 1", id_ready); end
    push_exp();
    @(negedge clk);
    idle();
    #1;
    n_cmp++;
    if (ex_a !== 8'h00 || ex_b !== 8'h00) begin n_err++; $display("FAIL zero_reader_ops: got a=%h b=%h want 00 00", ex_a, ex_b); end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      drive_id(OW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)), 1'b1,
               AW'($urandom_range(0, 15)), 1'b1, AW'($urandom_range(0, 15)), 1'b0,
               W'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
               W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
      #1;
      n_cmp++;
      if (id_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready %0d: got %b want 1", k, id_ready); end
      push_exp();
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    ex_ready = 1'b0;
    drive_id(OP_XOR, 4'd1, 1'b1, 4'd2, 1'b1, 4'd6, 1'b1, 8'h00, 1'b0, 8'h3C, 8'h5A);
    #1;
    n_cmp++;
    if (id_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_first: got %b want 1", id_ready); end
    push_exp();
    @(negedge clk);
    drive_id(OP_SLL, 4'd8, 1'b1, 4'd0, 1'b0, 4'd9, 1'b1, 8'h01, 1'b1, 8'h77, 8'h00);
    for (int i = 0; i < 2; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      n_cmp++;
      if (ex_valid !== 1'b1 || ex_op !== OP_XOR || ex_a !== 8'h3C || ex_b !== 8'h5A || ex_rd_addr !== 4'd6 || ex_rd_we !== 1'b1) begin
        n_err++;
        $display("FAIL bp_hold %0d: got v=%b op=%h a=%h b=%h rd=%h we=%b want v=1 op=4 a=3c b=5a rd=6 we=1",
                 i, ex_valid, ex_op, ex_a, ex_b, ex_rd_addr, ex_rd_we);
      end
      n_cmp++;
      if (id_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall %0d: got %b want 0", i, id_ready); end
    end
    @(negedge clk);
    ex_ready = 1'b1;
    #1;
    n_cmp++;
    if (id_ready !== 1'b1) begin n_err++; $display("FAIL bp_release: got %b want 1", id_ready); end
    push_exp();
    @(negedge clk);
    drive_id(OP_SRL, 4'd6, 1'b1, 4'd0, 1'b0, 4'd6, 1'b1, 8'h02, 1'b1, 8'h00, 8'h00);
    wb_we = 1'b1; wb_addr = 4'd6; wb_data = 8'h42;
    #1;
    n_cmp++;
    if (id_ready !== 1'b1) begin n_err++; $display("FAIL soc_ready: got %b want 1", id_ready); end
    push_exp();
    @(negedge clk);
    wb_we = 1'b0;
    idle();
    #1;
    n_cmp++;
    if (dut.u_sb.pending_o[6] !== 1'b1 || dut.u_sb.pending_o[9] !== 1'b1) begin
      n_err++; $display("FAIL soc_pending: got %h want 0240", dut.u_sb.pending_o);
    end
    n_cmp++;
    if (ex_a !== 8'h42) begin n_err++; $display("FAIL soc_bypass_a: got %h want 42", ex_a); end
    @(negedge clk);
    wb_we = 1'b1; wb_addr = 4'd6; wb_data = 8'h00;
    @(negedge clk);
    wb_addr = 4'd9;
    @(negedge clk);
    wb_we = 1'b0;
    #1;
    n_cmp++;
    if (dut.u_sb.pending_o !== 16'h0) begin n_err++; $display("FAIL bp_cleanup: got %h want 0000", dut.u_sb.pending_o); end
  endtask

  task automatic test_flush();
    exp_t dropped;
    @(negedge clk);
    ex_ready = 1'b0;
    drive_id(OP_LD, 4'd1, 1'b1, 4'd0, 1'b0, 4'd7, 1'b1, 8'h34, 1'b1, 8'h12, 8'h00);
    #1;
    n_cmp++;
    if (id_ready !== 1'b1) begin n_err++; $display("FAIL flush_issue_ready: got %b want 1", id_ready); end
    push_exp();
    @(negedge clk);
    idle();
    #1;
    n_cmp++;
    if (ex_valid !== 1'b1 || dut.u_sb.pending_o[7] !== 1'b1) begin
      n_err++; $display("FAIL flush_pre: got v=%b p7=%b want 1 1", ex_valid, dut.u_sb.pending_o[7]);
    end
    @(negedge clk);
    flush = 1'b1;
    drive_id(OP_ST, 4'd2, 1'b1, 4'd3, 1'b1, 4'd8, 1'b0, 8'h00, 1'b0, 8'h01, 8'h02);
    #1;
    n_cmp++;
    if (id_ready !== 1'b0) begin n_err++; $display("FAIL flush_ready: got %b want 0", id_ready); end
    dropped = exp_q.pop_back();
    @(negedge clk);
    flush = 1'b0;
    idle();
    #1;
    n_cmp++;
    if (ex_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", ex_valid); end
    n_cmp++;
    if (dut.u_sb.pending_o !== 16'h0) begin n_err++; $display("FAIL flush_pending: got %h want 0000", dut.u_sb.pending_o); end
    ex_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    ex_ready = 1'b0;
    drive_id(OP_ADD, 4'd1, 1'b1, 4'd0, 1'b0, 4'd3, 1'b1, 8'h09, 1'b1, 8'hC3, 8'h00);
    #1;
    n_cmp++;
    if (id_ready !== 1'b1) begin n_err++; $display("FAIL rmid_issue_ready: got %b want 1", id_ready); end
    push_exp();
    @(negedge clk);
    idle();
    #1;
    n_cmp++;
    if (ex_valid !== 1'b1 || dut.u_sb.pending_o[3] !== 1'b1 || ex_a !== 8'hC3) begin
      n_err++; $display("FAIL rmid_pre: got v=%b p3=%b a=%h want 1 1 c3", ex_valid, dut.u_sb.pending_o[3], ex_a);
    end
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (ex_valid !== 1'b0 || ex_a !== 8'h00 || dut.u_sb.pending_o !== 16'h0) begin
      n_err++; $display("FAIL rmid_async: got v=%b a=%h p=%h want 0 00 0000", ex_valid, ex_a, dut.u_sb.pending_o);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    ex_ready = 1'b1;
    drive_id(OP_OR, 4'd3, 1'b1, 4'd0, 1'b0, 4'd3, 1'b0, 8'h00, 1'b1, 8'h66, 8'h00);
    #1;
    n_cmp++;
    if (id_ready !== 1'b1) begin n_err++; $display("FAIL rmid_r3_ready: got %b want 1", id_ready); end
    push_exp();
    @(negedge clk);
    idle();
    #1;
    n_cmp++;
    if (ex_a !== 8'h66) begin n_err++; $display("FAIL rmid_r3_a: got %h want 66", ex_a); end
  endtask

  // ---------------- main sequence and report ----------------
  initial begin
    rst = 1'b1; ex_ready = 1'b0; flush = 1'b0;
    id_valid = 1'b0; id_op = '0; id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; id_rd_we = 1'b0; id_imm = '0; id_use_imm = 1'b0;
    rs1_data = '0; rs2_data = '0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;

    test_reset();
    test_basic();
    test_raw_bypass();
    test_zero_reg();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid();

    repeat (3) @(negedge clk);
    #3;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL sb_drain: got %0d outstanding want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/operand_stage.md
Name: operand_stage

Overview:
- Register-read/issue stage between instruction decode and execute.
- Drives the register-file read addresses and collects the operands.
- Bypasses same-cycle write-back data and tracks in-flight destinations in a scoreboard, stalling decode on RAW/WAW hazards.
- Presents a registered operand bundle to execute over a valid/ready handshake.

Parameters:
- ADDR_WIDTH, 4, register address width (2**ADDR_WIDTH registers).
- WIDTH, 8, data width.
- OP_WIDTH, 4, opaque opcode field passed to execute.
- ZERO_REG, 1, when 1 register 0 reads as zero and is never tracked.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- id_valid  in  1  decode offers an instruction.
- id_ready  out  1  stage accepts the instruction this cycle.
- id_op  in  OP_WIDTH  opcode.
- id_rs1_addr, id_rs2_addr  in  ADDR_WIDTH  source registers.
- id_rs1_used, id_rs2_used  in  1  source is actually read.
- id_rd_addr  in  ADDR_WIDTH  destination register.
- id_rd_we  in  1  instruction writes rd.
- id_imm  in  WIDTH  immediate.
- id_use_imm  in  1  operand B is the immediate.
- rs1_addr, rs2_addr  out  ADDR_WIDTH  register-file read addresses; combinational copy of id_rs*_addr.
- rs1_data, rs2_data  in  WIDTH  register-file read data (combinational).
- wb_we  in  1  write-back strobe; same net as the register-file write enable.
- wb_addr  in  ADDR_WIDTH  write-back address.
- wb_data  in  WIDTH  write-back data.
- flush  in  1  discard the held instruction.
- ex_valid  out  1  operand bundle valid.
- ex_ready  in  1  execute consumes the bundle.
- ex_op  out  OP_WIDTH  opcode.
- ex_a, ex_b  out  WIDTH  operands.
- ex_rd_addr  out  ADDR_WIDTH  destination register.
- ex_rd_we  out  1  destination write enable.

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values:
  - ex_valid=0.
  - ex_op, ex_a, ex_b, ex_rd_addr and ex_rd_we are all 0.
  - All pending bits are 0.
  - A reset mid-operation discards the held bundle and all scoreboard state.
- Scoreboard: pending[2**ADDR_WIDTH] holds one bit per register.
- Zero detection: z(r) = ZERO_REG && r==0.
- Clear event: clr(r) = wb_we && wb_addr==r.
- Hazards:
  - raw1 = id_rs1_used && !z(rs1) && pending[rs1] && !clr(rs1). raw2 is the same for rs2.
  - waw = id_rd_we && !z(rd) && pending[rd] && !clr(rd).
- Ready: id_ready = !rst && !flush && !raw1 && !raw2 && !waw && (!ex_valid || ex_ready).
- Accept: accept = id_valid && id_ready. On accept, the bundle registers load at the next edge; latency from accept to ex_valid is 1 cycle.
- Operand A:
  - 0 if z(rs1).
  - wb_data if clr(rs1), which bypasses the register file's old value on a same-cycle write.
  - Otherwise rs1_data.
- Operand B:
  - id_imm if id_use_imm.
  - Otherwise the same rule as A, applied to rs2.
- ex_valid next-state:
  - flush → 0.
  - Else accept → 1.
  - Else ex_ready → 0.
  - Else hold.
- Hold rule: while ex_valid && !ex_ready, all ex_* outputs are stable.
- Pending update, per register each cycle:
  - A set from an accept with id_rd_we && !z(rd) wins over a same-cycle clear to the same register.
  - Otherwise clr clears the bit.
  - flush clears the pending bit of the held bundle's rd, if ex_rd_we and ex_valid.
  - A flush never clears bits set by bundles already consumed by execute.
- Sources not used (rs*_used=0) never stall and their operand value is don't-care (bypass rules still apply).
- wb_we to an address not pending is legal and has no scoreboard effect.
- Back-to-back issue with no hazards sustains 1 instruction/cycle when ex_ready=1.

Decomposition:
- Shared package cpu_pkg: OP_WIDTH-sized opcode typedef and opcode constants; the operand bundle struct (op, a, b, rd_addr, rd_we).
- One natural sub-module: scoreboard.
  - Inputs: set_en/set_addr, clr_en/clr_addr, flush_clr_en/flush_clr_addr.
  - Outputs: pending vector.
  - Owns the set-over-clear priority.

Test Plan:
- Reset mid-stream:
  - Stimulus: assert rst with ex_valid=1 and pending[3]=1.
  - Required: ex_valid=0, pending all 0 and ex_a=0, all asynchronously.
  - Required after deassert: an instruction reading r3 issues without stall.
- Basic issue:
  - Stimulus: rs1=2 (rs1_data=0x11), imm=0x05, use_imm=1, rd=4.
  - Required: next cycle ex_valid=1, ex_a=0x11, ex_b=0x05, ex_rd_addr=4, pending[4]=1.
- RAW stall then bypass:
  - Stimulus: issue rd=4, then an instruction reading r4; id_ready stays 0 for 3 cycles. Then wb_we=1, wb_addr=4, wb_data=0xA5 with stale rs1_data=0x00.
  - Required: id_ready=1 that cycle and ex_a=0xA5 next cycle.
- Zero register:
  - Stimulus: rs1=0, rs1_data=0xFF, then rd=0 with id_rd_we=1.
  - Required: ex_a=0x00; pending[0] remains 0; a following reader of r0 never stalls.
- Backpressure and set-over-clear:
  - Stimulus: hold ex_ready=0 for 2 cycles. Then, in the same cycle, issue rd=6 with wb_we to r6 while pending[6]=1.
  - Required: ex_* stable while ex_ready=0; pending[6]=1 after the same-cycle issue and clear.
- Flush:
  - Stimulus: flush with held bundle rd=7 unconsumed.
  - Required: ex_valid=0 and pending[7]=0 next cycle; id_ready=0 during the flush cycle.
